pipelined_alu: RTL
==================

// Module: pipelined_alu
// PURPOSE
//  Parametrised successor to the team's single-cycle 3-bit-opcode ALU: WIDTH-bit datapath,
//  4-bit opcode, registered result with status flags, valid/ready handshake on both sides,
//  multi-cycle shift-add multiply. Sits between an issue stage and a writeback consumer.
// PARAMETERS
//  WIDTH  32  datapath width; power of two, 8..64. SHW = $clog2(WIDTH) derived locally.
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      reset, asynchronous, active-low
//  in_valid   in   1      op/a/b valid
//  in_ready   out  1      ALU accepts op this cycle
//  op         in   4      opcode, table below
//  a, b       in   WIDTH  operands
//  out_valid  out  1      y/flags valid
//  out_ready  in   1      consumer takes result this cycle
//  y          out  WIDTH  result (registered)
//  zero, neg  out  1      y==0 ; y[WIDTH-1]
//  carry      out  1      carry/borrow/shifted-out bit (see rules)
//  ovf        out  1      signed overflow
// BEHAVIOUR
//  Opcodes: 0 y=a | 1 a+b | 2 a-b | 3 a&b | 4 a|b | 5 a+1 | 6 a-1 | 7 y=b | 8 a^b
//   9 a<<b[SHW-1:0] | 10 a>>b[SHW-1:0] logical | 11 a>>>b[SHW-1:0] arith
//   12 MUL low WIDTH bits of a*b (multi-cycle) | 13 SLT signed (y=1/0) | 14 SLTU | 15 ~a
//  Reset (rst_n=0, async): state=IDLE, out_valid=0, y=0, all flags 0, counter 0.
//  Accept: fire_in = in_valid & in_ready. in_ready = (state==IDLE) & (!out_valid | out_ready).
//  Drain: fire_out = out_valid & out_ready; out_valid clears on fire_out unless new result loads.
//  Single-cycle ops (all except 12): result+flags written on the accepting edge;
//   out_valid=1 the cycle after accept (latency 1). Back-to-back accepts allowed when
//   out_ready=1 continuously (throughput 1/cycle).
//  FSM: IDLE -> MUL on fire_in with op==12; MUL -> IDLE after WIDTH iterations.
//   MUL: latch a,b; clear acc; counter 0..WIDTH-1; each edge acc += (mcand<<cnt) if mplier[cnt]
//   (mod 2^WIDTH). On edge with cnt==WIDTH-1 write y=final acc, out_valid=1, go IDLE.
//   out_valid rises WIDTH cycles after the accept edge; in_ready=0 throughout MUL.
//   Output register is guaranteed empty during MUL (accept required it free/draining).
//  Outputs held stable while out_valid=1 & out_ready=0; inputs ignored unless fire_in.
//  Flag rules (all computed on the loaded y):
//   ADD/INC: carry = bit WIDTH of unsigned sum; ovf = signed overflow.
//   SUB/DEC: carry = borrow (a < subtrahend, unsigned); ovf = signed overflow.
//   SHL/SHR/SRA: carry = last bit shifted out; shamt 0 -> carry=0; ovf=0.
//   All other ops incl. MUL: carry=0, ovf=0. zero/neg always from y.
//  Wrap: all arithmetic modulo 2^WIDTH; INC of all-ones -> 0, carry=1; DEC of 0 -> all-ones, carry=1.
//  Simultaneous fire_out & fire_in same cycle: old result leaves, new result loads; out_valid stays 1.
//  Reset mid-MUL: aborts, no result emitted, IDLE after rst_n deasserts.
// TESTING (WIDTH=8 unless noted)
//  ADD a=FF b=01 -> next cycle y=00, zero=1, carry=1, ovf=0, neg=0.
//  SUB a=80 b=01 -> y=7F, ovf=1, carry=0; DEC a=00 -> y=FF, carry=1, neg=1.
//  SRA a=90 b=03 -> y=F2, carry=0; SHL a=81 b=01 -> y=02, carry=1; SLT a=FF b=01 -> y=01.
//  MUL a=0D b=0B -> in_ready=0 for 8 cycles, out_valid 8 cycles after accept, y=8F;
//   MUL a=FF b=FF -> y=01.
//  Backpressure: out_ready=0, two ADDs presented -> first held stable, in_ready=0 until
//   out_ready=1; then same-cycle drain+accept keeps out_valid=1 (no bubble).
//  Pull rst_n low at MUL iteration 4 -> out_valid=0, y=0 immediately; after release
//   in_ready=1, ADD 02+03 returns 05 with latency 1. Repeat all at WIDTH=32 with random ops
//   against a reference model.

Source files
------------

// File: rtl/pipelined_alu_if.sv
// pipelined_alu_if: handshake and data bundle between an issue stage, the ALU
// and a writeback consumer.
//   in_valid/in_ready     : issue-side handshake for op/a/b
//   op, a, b              : opcode and WIDTH-bit operands
//   out_valid/out_ready   : writeback-side handshake for y and flags
//   y, zero, neg, carry, ovf : registered result and status flags
// master = issue/writeback side, slave = ALU side.
interface pipelined_alu_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             ovf;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, zero, neg, carry, ovf
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, zero, neg, carry, ovf
  );
endinterface

// File: rtl/pipelined_alu.sv
// pipelined_alu: WIDTH-bit ALU with a registered result, status flags,
// valid/ready handshake on both sides and a multi-cycle shift-add multiply.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pipelined_alu_if.slave (in_valid/in_ready/op/a/b in,
//           out_valid/out_ready/y/zero/neg/carry/ovf out)
//
// state | meaning
// IDLE  | single-cycle ops complete on the accepting edge; MUL may be accepted
// MUL   | shift-add multiply in progress, one multiplier bit per edge
module pipelined_alu #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  pipelined_alu_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_PASSA = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_INC   = 4'd5;
  localparam logic [3:0] OP_DEC   = 4'd6;
  localparam logic [3:0] OP_PASSB = 4'd7;
  localparam logic [3:0] OP_XOR   = 4'd8;
  localparam logic [3:0] OP_SHL   = 4'd9;
  localparam logic [3:0] OP_SHR   = 4'd10;
  localparam logic [3:0] OP_SRA   = 4'd11;
  localparam logic [3:0] OP_MUL   = 4'd12;
  localparam logic [3:0] OP_SLT   = 4'd13;
  localparam logic [3:0] OP_SLTU  = 4'd14;
  localparam logic [3:0] OP_NOT   = 4'd15;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;

  logic             out_valid_q;
  logic [WIDTH-1:0] y_q;
  logic             zero_q;
  logic             neg_q;
  logic             carry_q;
  logic             ovf_q;

  logic             in_ready_w;
  logic             fire_in;
  logic             fire_out;

  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;
  logic [WIDTH:0]   wide;
  logic [SHW-1:0]   shamt;
  logic             a_msb;
  logic             b_msb;

  assign in_ready_w = (state == IDLE) && (!out_valid_q || bus.out_ready);
  assign fire_in    = bus.in_valid && in_ready_w;
  assign fire_out   = out_valid_q && bus.out_ready;

  assign shamt = bus.b[SHW-1:0];
  assign a_msb = bus.a[WIDTH-1];
  assign b_msb = bus.b[WIDTH-1];

  // Shifts run on a WIDTH+1 vector so the last bit shifted out lands in the
  // extra bit; a zero shift leaves that bit at 0 for free.
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    wide  = '0;
    case (bus.op)
      OP_PASSA: res = bus.a;
      OP_ADD: begin
        wide  = {1'b0, bus.a} + {1'b0, bus.b};
        res   = wide[WIDTH-1:0];
        res_c = wide[WIDTH];
        res_v = (a_msb == b_msb) && (res[WIDTH-1] != a_msb);
      end
      OP_SUB: begin
        wide  = {1'b0, bus.a} - {1'b0, bus.b};
        res   = wide[WIDTH-1:0];
        res_c = wide[WIDTH];
        res_v = (a_msb != b_msb) && (res[WIDTH-1] != a_msb);
      end
      OP_AND:   res = bus.a & bus.b;
      OP_OR:    res = bus.a | bus.b;
      OP_INC: begin
        wide  = {1'b0, bus.a} + (WIDTH+1)'(1);
        res   = wide[WIDTH-1:0];
        res_c = wide[WIDTH];
        res_v = !a_msb && res[WIDTH-1];
      end
      OP_DEC: begin
        wide  = {1'b0, bus.a} - (WIDTH+1)'(1);
        res   = wide[WIDTH-1:0];
        res_c = wide[WIDTH];
        res_v = a_msb && !res[WIDTH-1];
      end
      OP_PASSB: res = bus.b;
      OP_XOR:   res = bus.a ^ bus.b;
      OP_SHL: begin
        wide  = {1'b0, bus.a} << shamt;
        res   = wide[WIDTH-1:0];
        res_c = wide[WIDTH];
      end
      OP_SHR: begin
        wide  = {bus.a, 1'b0} >> shamt;
        res   = wide[WIDTH:1];
        res_c = wide[0];
      end
      OP_SRA: begin
        wide  = $signed({bus.a, 1'b0}) >>> shamt;
        res   = wide[WIDTH:1];
        res_c = wide[0];
      end
      OP_SLT:   res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU:  res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_NOT:   res = ~bus.a;
      default:  res = '0;
    endcase
  end

  assign acc_next = acc + (mplier[cnt] ? (mcand << cnt) : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      // A load below overrides this clear, giving drain+accept without a bubble.
      if (fire_out) out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (fire_in) begin
            if (bus.op == OP_MUL) begin
              mcand  <= bus.a;
              mplier <= bus.b;
              acc    <= '0;
              cnt    <= '0;
              state  <= MUL;
            end else begin
              y_q         <= res;
              zero_q      <= (res == '0);
              neg_q       <= res[WIDTH-1];
              carry_q     <= res_c;
              ovf_q       <= res_v;
              out_valid_q <= 1'b1;
            end
          end
        end
        MUL: begin
          acc <= acc_next;
          cnt <= cnt + SHW'(1);
          if (cnt == SHW'(WIDTH-1)) begin
            y_q         <= acc_next;
            zero_q      <= (acc_next == '0);
            neg_q       <= acc_next[WIDTH-1];
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.carry     = carry_q;
  assign bus.ovf       = ovf_q;
endmodule
